// File: rtl/reorder_buffer.sv
// In-order retirement buffer: accepts up to two dispatched rows per cycle, records
// three FU writebacks, and retires up to two completed entries per cycle in program order.
package reorder_buffer_pkg;
    typedef logic [31:0] word;
    typedef logic [5:0]  p_reg;

    typedef struct packed {
        logic       valid;
        logic [3:0] rob_number;
        p_reg       preg_dst;
        p_reg       old_preg_dst;
        word        data;
        logic       reg_write;
        logic       mem_write;
    } rob_row_struct;
endpackage

module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int N_ALLOC  = 2,
    parameter int N_CMPL   = 3,
    parameter int N_RETIRE = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  rob_row_struct                i_rob_rows        [0:N_ALLOC-1],
    input  logic                         i_cmpl_valid      [0:N_CMPL-1],
    input  logic [$clog2(DEPTH)-1:0]     i_cmpl_tag        [0:N_CMPL-1],
    input  word                          i_cmpl_data       [0:N_CMPL-1],
    output logic                         o_retire_valid    [0:N_RETIRE-1],
    output p_reg                         o_retire_dst      [0:N_RETIRE-1],
    output word                          o_retire_data     [0:N_RETIRE-1],
    output logic                         o_retire_regwrite [0:N_RETIRE-1],
    output logic                         o_retire_memwrite [0:N_RETIRE-1],
    output logic                         o_free_valid      [0:N_RETIRE-1],
    output p_reg                         o_free_preg       [0:N_RETIRE-1],
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_alloc_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic valid;
        logic complete;
        p_reg dst;
        p_reg old_dst;
        word  data;
        logic reg_write;
        logic mem_write;
    } entry_t;

    entry_t          entry_q [DEPTH];
    entry_t          entry_d [DEPTH];
    logic [AW-1:0]   head_q, head_d, tail_q, tail_d, wr_ptr_s, rd_ptr_s;
    logic [CW-1:0]   count_q, count_d, free_s, n_acc_s, n_ret_s;
    logic            alloc_err_q, alloc_err_d, full_q, full_d, empty_q, empty_d;
    logic            ret_valid_q [N_RETIRE], ret_valid_d [N_RETIRE];
    p_reg            ret_dst_q   [N_RETIRE], ret_dst_d   [N_RETIRE];
    word             ret_data_q  [N_RETIRE], ret_data_d  [N_RETIRE];
    logic            ret_rw_q    [N_RETIRE], ret_rw_d    [N_RETIRE];
    logic            ret_mw_q    [N_RETIRE], ret_mw_d    [N_RETIRE];
    logic            free_vld_q  [N_RETIRE], free_vld_d  [N_RETIRE];
    p_reg            free_preg_q [N_RETIRE], free_preg_d [N_RETIRE];
    logic            unused_row_data_s;

    // Row data is never stored: results arrive only through the completion ports.
    always_comb begin
        unused_row_data_s = 1'b0;
        for (int s = 0; s < N_ALLOC; s++) begin
            unused_row_data_s = unused_row_data_s ^ (^i_rob_rows[s].data);
        end
    end

    // Next-state: allocation, then completion, then retirement from start-of-cycle state.
    always_comb begin
        entry_d     = entry_q;
        alloc_err_d = alloc_err_q;
        free_s      = CW'(DEPTH) - count_q;
        n_acc_s     = '0;
        n_ret_s     = '0;
        wr_ptr_s    = tail_q;
        rd_ptr_s    = head_q;
        for (int r = 0; r < N_RETIRE; r++) begin
            ret_valid_d[r] = 1'b0;
            ret_dst_d[r]   = '0;
            ret_data_d[r]  = '0;
            ret_rw_d[r]    = 1'b0;
            ret_mw_d[r]    = 1'b0;
            free_vld_d[r]  = 1'b0;
            free_preg_d[r] = '0;
        end

        for (int s = 0; s < N_ALLOC; s++) begin
            if (i_rob_rows[s].valid) begin
                if (n_acc_s < free_s) begin
                    if (i_rob_rows[s].rob_number != wr_ptr_s) begin
                        alloc_err_d = 1'b1;
                    end else begin
                        alloc_err_d = alloc_err_d;
                    end
                    entry_d[wr_ptr_s].valid     = 1'b1;
                    entry_d[wr_ptr_s].complete  = 1'b0;
                    entry_d[wr_ptr_s].dst       = i_rob_rows[s].preg_dst;
                    entry_d[wr_ptr_s].old_dst   = i_rob_rows[s].old_preg_dst;
                    entry_d[wr_ptr_s].data      = '0;
                    entry_d[wr_ptr_s].reg_write = i_rob_rows[s].reg_write;
                    entry_d[wr_ptr_s].mem_write = i_rob_rows[s].mem_write;
                    wr_ptr_s = wr_ptr_s + AW'(1);
                    n_acc_s  = n_acc_s + CW'(1);
                end else begin
                    alloc_err_d = 1'b1;
                end
            end else begin
                n_acc_s = n_acc_s;
            end
        end
        tail_d = wr_ptr_s;

        // Later ports overwrite earlier ones, so the highest index wins on a shared tag.
        for (int p = 0; p < N_CMPL; p++) begin
            if (i_cmpl_valid[p] && entry_q[i_cmpl_tag[p]].valid) begin
                entry_d[i_cmpl_tag[p]].complete = 1'b1;
                entry_d[i_cmpl_tag[p]].data     = i_cmpl_data[p];
            end else begin
                n_ret_s = n_ret_s;
            end
        end

        for (int r = 0; r < N_RETIRE; r++) begin
            if ((n_ret_s == CW'(r)) && entry_q[rd_ptr_s].valid && entry_q[rd_ptr_s].complete) begin
                ret_valid_d[r] = 1'b1;
                ret_dst_d[r]   = entry_q[rd_ptr_s].dst;
                ret_data_d[r]  = entry_q[rd_ptr_s].data;
                ret_rw_d[r]    = entry_q[rd_ptr_s].reg_write;
                ret_mw_d[r]    = entry_q[rd_ptr_s].mem_write;
                if (entry_q[rd_ptr_s].reg_write && (entry_q[rd_ptr_s].old_dst != 6'd0)) begin
                    free_vld_d[r]  = 1'b1;
                    free_preg_d[r] = entry_q[rd_ptr_s].old_dst;
                end else begin
                    free_vld_d[r]  = 1'b0;
                end
                entry_d[rd_ptr_s] = '0;
                rd_ptr_s = rd_ptr_s + AW'(1);
                n_ret_s  = n_ret_s + CW'(1);
            end else begin
                rd_ptr_s = rd_ptr_s;
            end
        end
        head_d  = rd_ptr_s;
        count_d = count_q + n_acc_s - n_ret_s;
        full_d  = (count_d >= CW'(DEPTH-1));
        empty_d = (count_d == '0);
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            for (int r = 0; r < N_RETIRE; r++) begin
                ret_valid_q[r] <= 1'b0;
                ret_dst_q[r]   <= '0;
                ret_data_q[r]  <= '0;
                ret_rw_q[r]    <= 1'b0;
                ret_mw_q[r]    <= 1'b0;
                free_vld_q[r]  <= 1'b0;
                free_preg_q[r] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            alloc_err_q <= 1'b0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
        end else begin
            entry_q     <= entry_d;
            ret_valid_q <= ret_valid_d;
            ret_dst_q   <= ret_dst_d;
            ret_data_q  <= ret_data_d;
            ret_rw_q    <= ret_rw_d;
            ret_mw_q    <= ret_mw_d;
            free_vld_q  <= free_vld_d;
            free_preg_q <= free_preg_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            alloc_err_q <= alloc_err_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
        end
    end

    assign o_retire_valid    = ret_valid_q;
    assign o_retire_dst      = ret_dst_q;
    assign o_retire_data     = ret_data_q;
    assign o_retire_regwrite = ret_rw_q;
    assign o_retire_memwrite = ret_mw_q;
    assign o_free_valid      = free_vld_q;
    assign o_free_preg       = free_preg_q;
    assign o_full            = full_q;
    assign o_empty           = empty_q;
    assign o_count           = count_q;
    assign o_alloc_err       = alloc_err_q;
endmodule
